// File: rtl/audio_pkg.sv
// Shared defaults and saturation limits for the audio mixer blocks.
package audio_pkg;

    localparam int DEF_BITDEPTH = 14;
    localparam int DEF_VOLW     = 4;

    // Limits of a signed bd-bit sample; bd must stay below 32.
    function automatic int sat_hi(input int bd);
        return (1 << (bd - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int bd);
        return -(1 << (bd - 1));
    endfunction

endpackage

// File: rtl/mixer_channel_gain.sv
// One mixer voice: volume scaling (vol+1)/2^VOLW with floor rounding, plus channel enable.
module mixer_channel_gain
    import audio_pkg::*;
#(
    parameter int BITDEPTH = DEF_BITDEPTH,
    parameter int VOLW     = DEF_VOLW
) (
    input  logic signed [BITDEPTH-1:0] sample,
    input  logic        [VOLW-1:0]     vol,
    input  logic                       en,
    output logic signed [BITDEPTH-1:0] scaled
);

    localparam int PW = BITDEPTH + VOLW + 2;

    logic signed [VOLW+1:0] gain;
    logic signed [PW-1:0]   prod;
    logic                   unused_bits;

    assign gain = $signed({2'b00, vol}) + (VOLW + 2)'(1);
    assign prod = PW'(sample) * PW'(gain);

    // Gain never exceeds 1, so the floor-shifted product always fits BITDEPTH bits;
    // taking the slice is the arithmetic shift by VOLW.
    assign scaled      = en ? prod[VOLW +: BITDEPTH] : '0;
    assign unused_bits = ^{prod[PW-1:VOLW+BITDEPTH], prod[VOLW-1:0]};

endmodule

// File: rtl/audio_mixer4.sv
// Four-voice mixer with per-channel volume; registered output with a one-clk valid pulse.
// Build option AUDIO_MIXER4_SATURATE_EN: full-scale saturating sum instead of averaging.
module audio_mixer4
    import audio_pkg::*;
#(
    parameter int BITDEPTH = DEF_BITDEPTH,
    parameter int VOLW     = DEF_VOLW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_en,
    input  logic signed [BITDEPTH-1:0] in1,
    input  logic signed [BITDEPTH-1:0] in2,
    input  logic signed [BITDEPTH-1:0] in3,
    input  logic signed [BITDEPTH-1:0] in4,
    input  logic        [3:0]          ch_en,
    input  logic        [4*VOLW-1:0]   vol,
    output logic signed [BITDEPTH-1:0] mix,
    output logic                       mix_valid
);

    localparam int SW = BITDEPTH + 2;

    logic signed [BITDEPTH-1:0] voice  [4];
    logic signed [BITDEPTH-1:0] scaled [4];
    logic signed [SW-1:0]       sum;
    logic signed [BITDEPTH-1:0] result;

    assign voice[0] = in1;
    assign voice[1] = in2;
    assign voice[2] = in3;
    assign voice[3] = in4;

    for (genvar k = 0; k < 4; k++) begin : g_ch
        mixer_channel_gain #(
            .BITDEPTH(BITDEPTH),
            .VOLW    (VOLW)
        ) u_gain (
            .sample(voice[k]),
            .vol   (vol[k*VOLW +: VOLW]),
            .en    (ch_en[k]),
            .scaled(scaled[k])
        );
    end

    assign sum = SW'(scaled[0]) + SW'(scaled[1]) + SW'(scaled[2]) + SW'(scaled[3]);

`ifdef AUDIO_MIXER4_SATURATE_EN
    localparam logic signed [SW-1:0] SAT_HI = SW'(sat_hi(BITDEPTH));
    localparam logic signed [SW-1:0] SAT_LO = SW'(sat_lo(BITDEPTH));

    always_comb begin
        result = sum[BITDEPTH-1:0];
        if (sum > SAT_HI) begin
            result = SAT_HI[BITDEPTH-1:0];
        end else if (sum < SAT_LO) begin
            result = SAT_LO[BITDEPTH-1:0];
        end
    end
`else
    logic unused_lsbs;

    // Averaging: arithmetic shift by 2 of a BITDEPTH+2 sum always fits the output.
    assign result      = sum[SW-1:2];
    assign unused_lsbs = ^sum[1:0];
`endif

    // Output protocol: mix_valid is high for exactly the clk after each sample_en edge,
    // mix carries the new result in that same clk and holds it until the next strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mix       <= '0;
            mix_valid <= 1'b0;
        end else begin
            mix_valid <= sample_en;
            if (sample_en) begin
                mix <= result;
            end
        end
    end

endmodule

// File: tb/tb_audio_mixer4.sv
// Scoreboard bench for audio_mixer4: directed corner cases plus randomized samples.
module tb_audio_mixer4;

    logic               clk;
    logic               rst;
    logic               sample_en;
    logic signed [13:0] in1, in2, in3, in4;
    logic [3:0]         ch_en;
    logic [15:0]        vol;
    logic signed [13:0] mix;
    logic               mix_valid;

    logic [13:0] exp_q[$];
    logic [13:0] last_exp;
    int          vectors;
    int          miscompares;

    audio_mixer4 dut (
        .clk      (clk),
        .rst      (rst),
        .sample_en(sample_en),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .in4      (in4),
        .ch_en    (ch_en),
        .vol      (vol),
        .mix      (mix),
        .mix_valid(mix_valid)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int floordiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int gain_of(input int x, input int v, input bit e);
        if (!e) return 0;
        return floordiv(x * (v + 1), 16);
    endfunction

    function automatic int model_mix(input int a1, input int a2, input int a3, input int a4,
                                     input bit [3:0] en, input bit [15:0] v);
        int s;
        s = gain_of(a1, int'(v[3:0]), en[0]) + gain_of(a2, int'(v[7:4]), en[1])
          + gain_of(a3, int'(v[11:8]), en[2]) + gain_of(a4, int'(v[15:12]), en[3]);
`ifdef AUDIO_MIXER4_SATURATE_EN
        if (s > 8191) s = 8191;
        if (s < -8192) s = -8192;
        return s;
`else
        return floordiv(s, 4);
`endif
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops on every valid, otherwise mix must hold the last expected value.
    always @(negedge clk) begin
        if (!rst) begin
            last_exp = '0;
        end else if (mix_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                last_exp = exp_q.pop_front();
                check("mix", int'(mix), int'($signed(last_exp)));
            end
        end else begin
            check("mix_hold", int'(mix), int'($signed(last_exp)));
        end
    end

    // ---------------- drivers ----------------
    // Called just after a negedge; returns at the next negedge with sample_en still high.
    task automatic put_sample(input int a1, input int a2, input int a3, input int a4,
                              input bit [3:0] en, input bit [15:0] v);
        in1       = 14'(a1);
        in2       = 14'(a2);
        in3       = 14'(a3);
        in4       = 14'(a4);
        ch_en     = en;
        vol       = v;
        sample_en = 1'b1;
        exp_q.push_back(14'(model_mix(a1, a2, a3, a4, en, v)));
        @(negedge clk);
    endtask

    task automatic single(input int a1, input int a2, input int a3, input int a4,
                          input bit [3:0] en, input bit [15:0] v);
        put_sample(a1, a2, a3, a4, en, v);
        sample_en = 1'b0;
        @(negedge clk);
    endtask

    function automatic int rnd_sample();
        case ($urandom_range(0, 5))
            0:       return 8191;
            1:       return -8192;
            default: return int'($urandom_range(0, 16383)) - 8192;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int a, b, c, d;
        vectors     = 0;
        miscompares = 0;
        last_exp    = '0;
        rst         = 1'b0;
        sample_en   = 1'b0;
        in1 = '0; in2 = '0; in3 = '0; in4 = '0;
        ch_en = 4'h0;
        vol   = 16'h0;

        #12;
        check("reset_mix", int'(mix), 0);
        check("reset_valid", int'(mix_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Unity gain, all channels: valid pulse exactly one clk.
        put_sample(1000, 1000, 1000, 1000, 4'hF, 16'hFFFF);
        check("valid_pulse_hi", int'(mix_valid), 1);
        sample_en = 1'b0;
        @(negedge clk);
        check("valid_pulse_lo", int'(mix_valid), 0);
`ifdef AUDIO_MIXER4_SATURATE_EN
        check("unity_1000", int'(mix), 4000);
`else
        check("unity_1000", int'(mix), 1000);
`endif

        // Full-scale extremes.
        single(8191, 8191, 8191, 8191, 4'hF, 16'hFFFF);
        check("max_pos", int'(mix), 8191);
        single(-8192, -8192, -8192, -8192, 4'hF, 16'hFFFF);
        check("max_neg", int'(mix), -8192);

        // Half volume on one channel; others masked off.
        single(1000, 1000, 1000, 1000, 4'b0001, 16'hFFF7);
`ifdef AUDIO_MIXER4_SATURATE_EN
        check("half_vol", int'(mix), 500);
`else
        check("half_vol", int'(mix), 125);
`endif

        // Floor rounding of a small negative value.
        single(-1, 1000, 1000, 1000, 4'b0001, 16'h0000);
        check("floor_neg", int'(mix), -1);

        // Inputs wiggle with no strobe for 100 clks.
        for (int i = 0; i < 100; i++) begin
            in1 = 14'($urandom); in2 = 14'($urandom);
            in3 = 14'($urandom); in4 = 14'($urandom);
            ch_en = 4'($urandom); vol = 16'($urandom);
            @(negedge clk);
        end
        check("quiet_valid", int'(mix_valid), 0);
        check("quiet_mix", int'(mix), -1);

        // Asynchronous reset mid-run, with a strobe coinciding that must be dropped.
        single(1000, 1000, 1000, 1000, 4'hF, 16'hFFFF);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_mix", int'(mix), 0);
        check("async_rst_valid", int'(mix_valid), 0);
        in1 = 14'd500;
        ch_en = 4'hF;
        sample_en = 1'b1;
        repeat (2) @(negedge clk);
        sample_en = 1'b0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_mix", int'(mix), 0);
        check("post_rst_valid", int'(mix_valid), 0);

        // Back-to-back burst.
        for (int i = 0; i < 8; i++) begin
            a = rnd_sample(); b = rnd_sample(); c = rnd_sample(); d = rnd_sample();
            put_sample(a, b, c, d, 4'($urandom), 16'($urandom));
            check("b2b_valid", int'(mix_valid), 1);
        end
        sample_en = 1'b0;
        @(negedge clk);

        // Random samples with random gaps.
        for (int i = 0; i < 300; i++) begin
            a = rnd_sample(); b = rnd_sample(); c = rnd_sample(); d = rnd_sample();
            put_sample(a, b, c, d, 4'($urandom), 16'($urandom));
            sample_en = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                in1 = 14'($urandom);
                @(negedge clk);
            end
            if ($urandom_range(0, 1) == 1) sample_en = 1'b0;
        end
        sample_en = 1'b0;

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
